iram_loader: RTL and testbench

//   Byte-stream program loader feeding the micro core's instruction-RAM write port
//   (iram_wa/iram_wen/iram_din). Accepts bytes from the UART receiver, frames them into

---
 rtl/iram_loader.sv | 139 +++++++++++++
 tb/tb_iram_loader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_loader.sv
// Byte-stream program loader: frames UART bytes into instruction words for the micro
// core's IRAM and releases the core once a frame with a good checksum has landed.
module iram_loader #(
    parameter int          WIDTH          = 16,
    parameter int          IRAM_ADDR_BITS = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT        = 1000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [IRAM_ADDR_BITS-1:0] iram_wa,
    output logic                      iram_wen,
    output logic [WIDTH-1:0]          iram_din,
    output logic                      loading,
    output logic                      cpu_run,
    output logic                      load_done,
    output logic                      load_err,
    output logic [IRAM_ADDR_BITS:0]   words_loaded
);

    localparam int AW = IRAM_ADDR_BITS;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;

    // A count byte of 0 stands for a full IRAM, which needs the extra top bit.
    localparam logic [8:0]    MAX_WORDS  = 9'(1 << AW);
    localparam logic [AW:0]   FULL_COUNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   ONE_WORD   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_ADDR   = AW'(1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    logic [2:0]    state;
    logic [AW-1:0] addr;
    logic [AW:0]   target;
    logic [7:0]    hi_byte;
    logic [7:0]    csum;
    logic [TW-1:0] timer;
    logic          timeout_hit;
    logic [AW:0]   words_next;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout_hit = (state != S_IDLE) && !rx_valid && (timer == TIMER_LAST);
    assign words_next  = words_loaded + ONE_WORD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            addr         <= '0;
            target       <= '0;
            hi_byte      <= '0;
            csum         <= '0;
            timer        <= '0;
            iram_wa      <= '0;
            iram_wen     <= 1'b0;
            iram_din     <= '0;
            loading      <= 1'b0;
            cpu_run      <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            iram_wen  <= 1'b0;
            load_done <= 1'b0;

            if (state == S_IDLE || rx_valid) begin
                timer <= '0;
            end else begin
                timer <= timer + TIMER_ONE;
            end

            if (timeout_hit) begin
                load_err <= 1'b1;
                state    <= S_IDLE;
                loading  <= 1'b0;
            end else if (rx_valid) begin
                case (state)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            cpu_run      <= 1'b0;
                            load_err     <= 1'b0;
                            words_loaded <= '0;
                            state        <= S_COUNT;
                            loading      <= 1'b1;
                        end
                    end
                    S_COUNT: begin
                        if ({1'b0, rx_data} > MAX_WORDS) begin
                            load_err <= 1'b1;
                            state    <= S_IDLE;
                            loading  <= 1'b0;
                        end else begin
                            target <= (rx_data == 8'd0) ? FULL_COUNT : (AW+1)'(rx_data);
                            addr   <= '0;
                            csum   <= '0;
                            state  <= S_HI;
                        end
                    end
                    S_HI: begin
                        hi_byte <= rx_data;
                        csum    <= csum ^ rx_data;
                        state   <= S_LO;
                    end
                    S_LO: begin
                        csum         <= csum ^ rx_data;
                        iram_wa      <= addr;
                        iram_din     <= WIDTH'({hi_byte, rx_data});
                        iram_wen     <= 1'b1;
                        addr         <= addr + ONE_ADDR;
                        words_loaded <= words_next;
                        state        <= (words_next == target) ? S_CSUM : S_HI;
                    end
                    S_CSUM: begin
                        if (rx_data == csum) begin
                            cpu_run   <= 1'b1;
                            load_done <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                        end
                        state   <= S_IDLE;
                        loading <= 1'b0;
                    end
                    default: begin
                        state   <= S_IDLE;
                        loading <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iram_loader.sv
// Self-checking bench for iram_loader: directed frames plus randomized traffic checked
// every cycle against a byte-position model of the load protocol.
module tb_iram_loader;

    localparam int         AB    = 8;
    localparam int         DEPTH = 1 << AB;
    localparam int         TO    = 40;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [AB-1:0] iram_wa;
    logic          iram_wen;
    logic [15:0]   iram_din;
    logic          loading;
    logic          cpu_run;
    logic          load_done;
    logic          load_err;
    logic [AB:0]   words_loaded;

    int checks = 0;
    int failures = 0;

    iram_loader #(
        .WIDTH(16),
        .IRAM_ADDR_BITS(AB),
        .SYNC_BYTE(SYNC),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .iram_wa(iram_wa),
        .iram_wen(iram_wen),
        .iram_din(iram_din),
        .loading(loading),
        .cpu_run(cpu_run),
        .load_done(load_done),
        .load_err(load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model tracks the byte position inside a frame rather than any state machine.
    bit          m_in_frame = 0;
    int          m_pos = 0;
    int          m_n = 0;
    int          m_quiet = 0;
    int          m_words = 0;
    logic [7:0]  m_csum = 0;
    logic [7:0]  m_hi = 0;
    logic        m_wen = 0;
    logic        m_run = 0;
    logic        m_done = 0;
    logic        m_err = 0;
    logic [7:0]  m_wa = 0;
    logic [15:0] m_din = 0;
    logic [15:0] m_mem [DEPTH];
    logic [15:0] dut_mem [DEPTH];
    int          wen_count = 0;
    int          done_count = 0;
    logic [7:0]  last_wa = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 16'h0;
            dut_mem[i] = 16'h0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_in_frame = 0;
            m_pos = 0;
            m_quiet = 0;
            m_words = 0;
            m_csum = 0;
            m_hi = 0;
            m_wen = 0;
            m_run = 0;
            m_done = 0;
            m_err = 0;
            m_wa = 0;
            m_din = 0;
        end else begin
            m_wen = 0;
            m_done = 0;
            if (!m_in_frame) begin
                if (rx_valid && rx_data == SYNC) begin
                    m_in_frame = 1;
                    m_pos = 0;
                    m_run = 0;
                    m_err = 0;
                    m_words = 0;
                    m_quiet = 0;
                end
            end else if (!rx_valid) begin
                m_quiet++;
                if (m_quiet == TO) begin
                    m_err = 1;
                    m_in_frame = 0;
                end
            end else begin
                m_quiet = 0;
                if (m_pos == 0) begin
                    m_n = (rx_data == 8'd0) ? DEPTH : int'(rx_data);
                    if (m_n > DEPTH) begin
                        m_err = 1;
                        m_in_frame = 0;
                    end else begin
                        m_csum = 0;
                        m_pos = 1;
                    end
                end else if (m_pos <= 2 * m_n) begin
                    m_csum = m_csum ^ rx_data;
                    if (m_pos % 2 == 1) begin
                        m_hi = rx_data;
                    end else begin
                        m_wen = 1;
                        m_wa = 8'((m_pos / 2 - 1) % DEPTH);
                        m_din = {m_hi, rx_data};
                        m_mem[m_wa] = m_din;
                        m_words++;
                    end
                    m_pos++;
                end else begin
                    if (rx_data == m_csum) begin
                        m_run = 1;
                        m_done = 1;
                    end else begin
                        m_err = 1;
                    end
                    m_in_frame = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("iram_wen", 32'(iram_wen), 32'(m_wen));
        checkOutput("iram_wa", 32'(iram_wa), 32'(m_wa));
        checkOutput("iram_din", 32'(iram_din), 32'(m_din));
        checkOutput("loading", 32'(loading), 32'(m_in_frame));
        checkOutput("cpu_run", 32'(cpu_run), 32'(m_run));
        checkOutput("load_done", 32'(load_done), 32'(m_done));
        checkOutput("load_err", 32'(load_err), 32'(m_err));
        checkOutput("words_loaded", 32'(words_loaded), 32'(m_words));
        if (iram_wen === 1'b1) begin
            dut_mem[iram_wa] = iram_din;
            last_wa = iram_wa;
            wen_count++;
        end
        if (load_done === 1'b1) done_count++;
    end

    // Caller must be at a falling edge; the byte is held for exactly one rising edge.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic sendFrame(input int n, input bit bad_csum, input int max_gap, input int abort_after);
        logic [7:0] cs;
        logic [7:0] b;
        int words;
        words = (n == 0) ? DEPTH : n;
        cs = 8'h00;
        applyStimulus(SYNC, $urandom_range(max_gap));
        applyStimulus(8'(n), $urandom_range(max_gap));
        for (int i = 0; i < 2 * words; i++) begin
            if (abort_after >= 0 && i == abort_after) begin
                repeat (TO + 3) @(negedge clk);
                return;
            end
            b = 8'($urandom);
            cs = cs ^ b;
            applyStimulus(b, $urandom_range(max_gap));
        end
        applyStimulus(bad_csum ? ~cs : cs, $urandom_range(max_gap));
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        int w0;
        int d0;
        logic [7:0] junk;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_wen", 32'(iram_wen), 0);
        checkOutput("rst_wa", 32'(iram_wa), 0);
        checkOutput("rst_din", 32'(iram_din), 0);
        checkOutput("rst_loading", 32'(loading), 0);
        checkOutput("rst_run", 32'(cpu_run), 0);
        checkOutput("rst_err", 32'(load_err), 0);
        checkOutput("rst_words", 32'(words_loaded), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] directed: good two-word frame");
        w0 = wen_count; d0 = done_count;
        applyStimulus(8'hA5, 0); applyStimulus(8'h02, 1); applyStimulus(8'h12, 0);
        applyStimulus(8'h34, 2); applyStimulus(8'hAB, 0); applyStimulus(8'hCD, 0);
        checkOutput("t1_loading_mid", 32'(loading), 1);
        applyStimulus(8'h40, 0);
        settle();
        checkOutput("t1_mem0", 32'(dut_mem[0]), 32'h1234);
        checkOutput("t1_mem1", 32'(dut_mem[1]), 32'hABCD);
        checkOutput("t1_model_mem1", 32'(m_mem[1]), 32'hABCD);
        checkOutput("t1_writes", 32'(wen_count - w0), 2);
        checkOutput("t1_done", 32'(done_count - d0), 1);
        checkOutput("t1_run", 32'(cpu_run), 1);
        checkOutput("t1_words", 32'(words_loaded), 2);
        checkOutput("t1_loading", 32'(loading), 0);

        $display("[TB] directed: bad checksum");
        w0 = wen_count; d0 = done_count;
        applyStimulus(8'hA5, 0); applyStimulus(8'h02, 0); applyStimulus(8'h12, 0);
        applyStimulus(8'h34, 0); applyStimulus(8'hAB, 0); applyStimulus(8'hCD, 0);
        applyStimulus(8'h41, 0);
        settle();
        checkOutput("t2_writes", 32'(wen_count - w0), 2);
        checkOutput("t2_err", 32'(load_err), 1);
        checkOutput("t2_model_err", 32'(m_err), 1);
        checkOutput("t2_run", 32'(cpu_run), 0);
        checkOutput("t2_done", 32'(done_count - d0), 0);

        $display("[TB] directed: timeout mid-frame");
        w0 = wen_count;
        applyStimulus(8'hA5, 0); applyStimulus(8'h02, 0); applyStimulus(8'h12, TO + 5);
        #1;
        checkOutput("t3_err", 32'(load_err), 1);
        checkOutput("t3_loading", 32'(loading), 0);
        checkOutput("t3_writes", 32'(wen_count - w0), 0);

        $display("[TB] directed: leading junk then good frame");
        applyStimulus(8'h00, 0); applyStimulus(8'hFF, 0); applyStimulus(8'h5A, 0);
        applyStimulus(8'hA5, 0); applyStimulus(8'h01, 0); applyStimulus(8'hC3, 0);
        applyStimulus(8'h3C, 0); applyStimulus(8'hFF, 0);
        settle();
        checkOutput("t5_mem0", 32'(dut_mem[0]), 32'hC33C);
        checkOutput("t5_err_cleared", 32'(load_err), 0);
        checkOutput("t5_run", 32'(cpu_run), 1);
        checkOutput("t5_words", 32'(words_loaded), 1);

        $display("[TB] directed: full-depth frame with N=0");
        w0 = wen_count;
        sendFrame(0, 0, 0, -1);
        settle();
        checkOutput("t4_writes", 32'(wen_count - w0), 256);
        checkOutput("t4_last_wa", 32'(last_wa), 32'hFF);
        checkOutput("t4_run", 32'(cpu_run), 1);
        checkOutput("t4_words", 32'(words_loaded), 256);

        $display("[TB] directed: reset mid-frame");
        applyStimulus(8'hA5, 0); applyStimulus(8'h02, 0); applyStimulus(8'h77, 0);
        applyStimulus(8'h88, 0);
        @(negedge clk);
        checkOutput("t6_loading_pre", 32'(loading), 1);
        checkOutput("t6_words_pre", 32'(words_loaded), 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_wen", 32'(iram_wen), 0);
        checkOutput("t6_din", 32'(iram_din), 0);
        checkOutput("t6_loading", 32'(loading), 0);
        checkOutput("t6_words", 32'(words_loaded), 0);
        checkOutput("t6_run", 32'(cpu_run), 0);
        checkOutput("t6_err", 32'(load_err), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(8'hA5, 0); applyStimulus(8'h01, 0); applyStimulus(8'h56, 0);
        applyStimulus(8'h78, 0); applyStimulus(8'h2E, 0);
        settle();
        checkOutput("t6_mem0", 32'(dut_mem[0]), 32'h5678);
        checkOutput("t6_last_wa", 32'(last_wa), 0);
        checkOutput("t6_run_after", 32'(cpu_run), 1);

        $display("[TB] randomized frames");
        @(negedge clk);
        for (int f = 0; f < 40; f++) begin
            for (int j = 0; j < int'($urandom_range(2)); j++) begin
                junk = 8'($urandom);
                if (junk == SYNC) junk = 8'h00;
                applyStimulus(junk, $urandom_range(2));
            end
            sendFrame($urandom_range(1, 12), ($urandom_range(3) == 0), 3,
                      ($urandom_range(5) == 0) ? int'($urandom_range(1, 2)) : -1);
            repeat ($urandom_range(3)) @(negedge clk);
        end
        settle();
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("mem[%0d]", i), 32'(dut_mem[i]), 32'(m_mem[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
